// File: rtl/irq_multi_sense.sv
// Multi-channel external interrupt front end: pin select, synchroniser, sense detect,
// latched pending flags and a fixed-priority request. Optional glitch filter: IRQ_GLITCH_FILTER_EN.
module irq_multi_sense #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     irq_pin_a,
  input  logic [NUM_CH-1:0]     irq_pin_b,
  input  logic [NUM_CH-1:0]     pin_sel,
  input  logic [2*NUM_CH-1:0]   sense_mode,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic                  isr_wr_en,
  input  logic [NUM_CH-1:0]     isr_wr_data,
  input  logic                  ack_valid,
  input  logic [4:0]            ack_id,
  input  logic [NUM_CH-1:0]     dtc_clr,
  output logic [NUM_CH-1:0]     isr_rd_data,
  output logic                  irq_req,
  output logic [4:0]            irq_id
);

  // Reject illegal configurations at elaboration time.
  if (NUM_CH < 1 || NUM_CH > 32 || SYNC_STAGES < 2 || FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_param_check
    $fatal(1, "irq_multi_sense: illegal parameter value");
  end

  logic [NUM_CH-1:0] pin_mux;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_val;
  logic [NUM_CH-1:0] det_val;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] det_evt;
  logic [NUM_CH-1:0] set_vec;
  logic [NUM_CH-1:0] clr_vec;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] active;
  logic [4:0]        enc_id;

  assign pin_mux = (irq_pin_a & pin_sel) | (irq_pin_b & ~pin_sel);

  // Pins are active-low, so the synchroniser idles at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
    end else begin
      sync_q[0] <= pin_mux;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];

`ifdef IRQ_GLITCH_FILTER_EN
  logic [3:0]        filt_cnt_q [NUM_CH];
  logic [NUM_CH-1:0] filt_q;

  // The filtered level follows sync only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '1;
      for (int i = 0; i < NUM_CH; i++) filt_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_val[i] == filt_q[i]) begin
          filt_cnt_q[i] <= '0;
        end else if (filt_cnt_q[i] == 4'(FILTER_LEN - 1)) begin
          filt_q[i]     <= sync_val[i];
          filt_cnt_q[i] <= '0;
        end else begin
          filt_cnt_q[i] <= filt_cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign det_val = filt_q;
`else
  assign det_val = sync_val;
`endif

  always_comb begin
    det_evt = '0;
    clr_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (sense_mode[2*i +: 2])
        2'b00:   det_evt[i] = ~det_val[i];
        2'b01:   det_evt[i] = prev_q[i] & ~det_val[i];
        2'b10:   det_evt[i] = ~prev_q[i] & det_val[i];
        default: det_evt[i] = prev_q[i] ^ det_val[i];
      endcase
      clr_vec[i] = (isr_wr_en & ~isr_wr_data[i]) | (ack_valid && (ack_id == 5'(i))) | dtc_clr[i];
    end
  end

  assign set_vec = det_evt & ch_en;
  assign active  = pend_q & ch_en;

  // prev tracks the detected level unconditionally so a mode or enable change cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '1;
      pend_q <= '0;
    end else begin
      prev_q <= det_val;
      pend_q <= set_vec | (pend_q & ~clr_vec);
    end
  end

  always_comb begin
    enc_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (active[i]) enc_id = 5'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      irq_req <= |active;
      irq_id  <= enc_id;
    end
  end

  assign isr_rd_data = pend_q;

endmodule

// File: tb/tb_irq_multi_sense.sv
// Directed bench for irq_multi_sense: latency, clear paths, priority, enable masking,
// and glitch filtering when IRQ_GLITCH_FILTER_EN is defined.
module tb_irq_multi_sense;

  localparam int NUM_CH = 8;
`ifdef IRQ_GLITCH_FILTER_EN
  localparam int FL = 3;
`else
  localparam int FL = 0;
`endif

  logic                clk;
  logic                rst_n;
  logic [NUM_CH-1:0]   irq_pin_a;
  logic [NUM_CH-1:0]   irq_pin_b;
  logic [NUM_CH-1:0]   pin_sel;
  logic [2*NUM_CH-1:0] sense_mode;
  logic [NUM_CH-1:0]   ch_en;
  logic                isr_wr_en;
  logic [NUM_CH-1:0]   isr_wr_data;
  logic                ack_valid;
  logic [4:0]          ack_id;
  logic [NUM_CH-1:0]   dtc_clr;
  logic [NUM_CH-1:0]   isr_rd_data;
  logic                irq_req;
  logic [4:0]          irq_id;

  int vectors     = 0;
  int miscompares = 0;

  irq_multi_sense #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (2),
    .FILTER_LEN  (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_pin_a   (irq_pin_a),
    .irq_pin_b   (irq_pin_b),
    .pin_sel     (pin_sel),
    .sense_mode  (sense_mode),
    .ch_en       (ch_en),
    .isr_wr_en   (isr_wr_en),
    .isr_wr_data (isr_wr_data),
    .ack_valid   (ack_valid),
    .ack_id      (ack_id),
    .dtc_clr     (dtc_clr),
    .isr_rd_data (isr_rd_data),
    .irq_req     (irq_req),
    .irq_id      (irq_id)
  );

  // Clock and time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "time limit");
  end

  // Advance n rising edges; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_clear(input logic [NUM_CH-1:0] mask);
    isr_wr_en   = 1'b1;
    isr_wr_data = mask;
    tick(1);
    isr_wr_en   = 1'b0;
    isr_wr_data = '1;
  endtask

  task automatic ack(input logic [4:0] id);
    ack_valid = 1'b1;
    ack_id    = id;
    tick(1);
    ack_valid = 1'b0;
    ack_id    = '0;
  endtask

  initial begin
    rst_n       = 1'b0;
    irq_pin_a   = '1;
    irq_pin_b   = 8'h7F;        // ch7 pin B held low through reset
    pin_sel     = 8'h5F;        // ch7 and ch5 use pin set B
    sense_mode  = 16'h5555;     // all falling edge
    ch_en       = '1;
    isr_wr_en   = 1'b0;
    isr_wr_data = '1;
    ack_valid   = 1'b0;
    ack_id      = '0;
    dtc_clr     = '0;
    tick(3);
    chk("reset_pend", isr_rd_data, 8'h00);
    chk("reset_req", irq_req, 1'b0);
    chk("reset_id", irq_id, 5'd0);

    // Pin low through reset gives a falling edge SYNC_STAGES+1 edges after release.
    rst_n = 1'b1;
    tick(2 + FL);
    chk("rst_low_early", isr_rd_data, 8'h00);
    tick(1);
    chk("rst_low_pend", isr_rd_data, 8'h80);
    tick(1);
    chk("rst_low_req", irq_req, 1'b1);
    chk("rst_low_id", irq_id, 5'd7);
    wr_clear(8'h7F);
    chk("rst_low_clr", isr_rd_data, 8'h00);
    tick(1);
    chk("rst_low_req_drop", irq_req, 1'b0);
    irq_pin_b[7] = 1'b1;
    tick(4 + FL);
    chk("rise_in_fall_mode", isr_rd_data, 8'h00);

    // Falling edge on ch3 via pin A.
    irq_pin_a[3] = 1'b0;
    tick(2 + FL);
    chk("ch3_pend_early", isr_rd_data, 8'h00);
    tick(1);
    chk("ch3_pend", isr_rd_data, 8'h08);
    chk("ch3_req_early", irq_req, 1'b0);
    tick(1);
    chk("ch3_req", irq_req, 1'b1);
    chk("ch3_id", irq_id, 5'd3);
    wr_clear(8'hF7);
    chk("ch3_clr_pend", isr_rd_data, 8'h00);
    chk("ch3_req_hold", irq_req, 1'b1);
    tick(1);
    chk("ch3_req_drop", irq_req, 1'b0);
    irq_pin_a[3] = 1'b1;
    tick(4 + FL);

    // Low-level mode on ch0: set dominates ack while the pin stays low.
    sense_mode[1:0] = 2'b00;
    tick(2);
    chk("ch0_idle", isr_rd_data, 8'h00);
    irq_pin_a[0] = 1'b0;
    tick(3 + FL);
    chk("ch0_pend", isr_rd_data, 8'h01);
    tick(1);
    chk("ch0_req", irq_req, 1'b1);
    chk("ch0_id", irq_id, 5'd0);
    ack(5'd0);
    chk("ch0_ack_blocked", isr_rd_data, 8'h01);
    irq_pin_a[0] = 1'b1;
    tick(3 + FL);
    chk("ch0_latched", isr_rd_data, 8'h01);
    ack(5'd0);
    chk("ch0_ack_clr", isr_rd_data, 8'h00);
    tick(2);
    chk("ch0_req_drop", irq_req, 1'b0);
    sense_mode[1:0] = 2'b01;

    // Both-edges mode on ch5 via pin B: 4-cycle low pulse.
    sense_mode[11:10] = 2'b11;
    tick(1);
    irq_pin_b[5] = 1'b0;
    tick(3 + FL);
    chk("ch5_fall_pend", isr_rd_data, 8'h20);
    dtc_clr[5] = 1'b1;
    tick(1);
    dtc_clr[5] = 1'b0;
    chk("ch5_dtc_clr", isr_rd_data, 8'h00);
    irq_pin_b[5] = 1'b1;
    tick(2 + FL);
    chk("ch5_rise_early", isr_rd_data, 8'h00);
    tick(1);
    chk("ch5_rise_pend", isr_rd_data, 8'h20);
    dtc_clr[5] = 1'b1;
    tick(1);
    dtc_clr[5] = 1'b0;
    chk("ch5_dtc_clr2", isr_rd_data, 8'h00);
    sense_mode[11:10] = 2'b01;
    tick(2);

    // Channels 2 and 6 together: lowest index wins, then the next.
    irq_pin_a[2] = 1'b0;
    irq_pin_a[6] = 1'b0;
    tick(4 + FL);
    chk("dual_pend", isr_rd_data, 8'h44);
    chk("dual_req", irq_req, 1'b1);
    chk("dual_id", irq_id, 5'd2);
    ack(5'd2);
    chk("dual_ack2", isr_rd_data, 8'h40);
    chk("dual_id_hold", irq_id, 5'd2);
    tick(1);
    chk("dual_id_next", irq_id, 5'd6);
    ack(5'd9);
    chk("ack_out_of_range", isr_rd_data, 8'h40);
    ack(5'd1);
    chk("ack_not_pending", isr_rd_data, 8'h40);
    ack(5'd6);
    chk("dual_ack6", isr_rd_data, 8'h00);
    tick(1);
    chk("dual_req_drop", irq_req, 1'b0);
    irq_pin_a[2] = 1'b1;
    irq_pin_a[6] = 1'b1;
    tick(4 + FL);

    // ch1 disabled: no new set.
    ch_en[1] = 1'b0;
    irq_pin_a[1] = 1'b0;
    tick(4 + FL);
    chk("ch1_disabled", isr_rd_data, 8'h00);
    irq_pin_a[1] = 1'b1;
    tick(4 + FL);

    // ch1 pending, then disabled: flag kept but masked.
    ch_en[1] = 1'b1;
    irq_pin_a[1] = 1'b0;
    tick(3 + FL);
    chk("ch1_pend", isr_rd_data, 8'h02);
    ch_en[1] = 1'b0;
    tick(1);
    chk("ch1_masked_req", irq_req, 1'b0);
    tick(1);
    chk("ch1_kept", isr_rd_data, 8'h02);
    chk("ch1_masked_req2", irq_req, 1'b0);
    ch_en[1] = 1'b1;
    tick(1);
    chk("ch1_unmask_req", irq_req, 1'b1);
    chk("ch1_unmask_id", irq_id, 5'd1);
    wr_clear(8'hFD);
    chk("ch1_clr", isr_rd_data, 8'h00);
    irq_pin_a[1] = 1'b1;
    tick(4 + FL);

`ifdef IRQ_GLITCH_FILTER_EN
    // 2-cycle glitch is rejected, 3-cycle pulse is accepted.
    irq_pin_a[4] = 1'b0;
    tick(2);
    irq_pin_a[4] = 1'b1;
    tick(10);
    chk("filt_glitch", isr_rd_data, 8'h00);
    irq_pin_a[4] = 1'b0;
    tick(3);
    irq_pin_a[4] = 1'b1;
    tick(2);
    chk("filt_pulse_early", isr_rd_data, 8'h00);
    tick(1);
    chk("filt_pulse_pend", isr_rd_data, 8'h10);
    wr_clear(8'hEF);
    chk("filt_clr", isr_rd_data, 8'h00);
    tick(8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
